// File: rtl/mycpu_pkg.sv
// +------------------------------------------------------------------+
// | mycpu_pkg : shared types, constants and helpers for mycpu        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package mycpu_pkg;

  typedef enum logic [1:0] {
    PS_HOLD = 2'b00,
    PS_INC  = 2'b01,
    PS_BRA  = 2'b10,
    PS_JMP  = 2'b11
  } pc_sel_t;

  localparam int BR_OFF_W = 6;

  // The branch offset is split across the instruction: bits [8:6] and [2:0].
  function automatic logic [15:0] sext_off(input logic [15:0] ins);
    logic [BR_OFF_W-1:0] off;
    off = {ins[8:6], ins[2:0]};
    return {{(16-BR_OFF_W){off[BR_OFF_W-1]}}, off};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_next_calc.sv
// +------------------------------------------------------------------+
// | pc_next_calc : combinational next-PC selection and bounds flag   |
// | Optional macro: MYCPU_PC_BOUNDS_EN. Rev 1.0                      |
// +------------------------------------------------------------------+
`default_nettype none

module pc_next_calc
  import mycpu_pkg::*;
#(
  parameter int              AW       = 8,
  parameter logic [AW-1:0]   PC_LIMIT = {AW{1'b1}}
) (
  input  logic [AW-1:0] pc,
  input  pc_sel_t       ps,
  input  logic [15:0]   ins,
  input  logic [AW-1:0] ra,
  output logic [AW-1:0] next_pc,
  output logic          oob
);

  logic [AW-1:0] w_off;

  assign w_off = AW'(sext_off(ins));

  always_comb begin
    next_pc = pc;
    case (ps)
      PS_HOLD: next_pc = pc;
      PS_INC:  next_pc = pc + AW'(1);
      PS_BRA:  next_pc = pc + w_off;
      PS_JMP:  next_pc = ra;
      default: next_pc = pc;
    endcase
  end

`ifdef MYCPU_PC_BOUNDS_EN
  assign oob = (ps != PS_HOLD) && (next_pc > PC_LIMIT);
`else
  logic w_unused_limit;
  assign w_unused_limit = ^PC_LIMIT;
  assign oob            = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// +------------------------------------------------------------------+
// | fetch_unit : PC, IR and fetch counter stage of mycpu             |
// | Optional macro: MYCPU_PC_BOUNDS_EN. Rev 1.0                      |
// +------------------------------------------------------------------+
`default_nettype none

module fetch_unit
  import mycpu_pkg::*;
#(
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter logic [AW-1:0] PC_LIMIT = {AW{1'b1}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    ps_in,
  input  logic          il_in,
  input  logic [15:0]   imem_data_in,
  input  logic [15:0]   ra_in,
  output logic [AW-1:0] pc_out,
  output logic [15:0]   ins_out,
  output logic [15:0]   fetch_cnt_out,
  output logic          trap_out
);

  localparam logic [15:0] c_cnt_max = 16'hFFFF;

  logic [AW-1:0] r_pc;
  logic [15:0]   r_ir;
  logic [15:0]   r_cnt;
  logic [AW-1:0] w_next_pc;
  logic          w_oob;
  pc_sel_t       w_ps;

  assign w_ps = pc_sel_t'(ps_in);

  pc_next_calc #(
    .AW       (AW),
    .PC_LIMIT (PC_LIMIT)
  ) u_pc_next_calc (
    .pc      (r_pc),
    .ps      (w_ps),
    .ins     (r_ir),
    .ra      (ra_in[AW-1:0]),
    .next_pc (w_next_pc),
    .oob     (w_oob)
  );

  generate
    if (AW < 16) begin : g_ra_unused
      logic w_unused_ra;
      assign w_unused_ra = ^ra_in[15:AW];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir  <= 16'h0000;
      r_cnt <= 16'h0000;
    end else if (il_in) begin
      r_ir <= imem_data_in;
      if (r_cnt != c_cnt_max) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

`ifdef MYCPU_PC_BOUNDS_EN
  logic r_trap;

  // Once trapped, every PC command degrades to hold until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc   <= RESET_PC;
      r_trap <= 1'b0;
    end else if (!r_trap && (w_ps != PS_HOLD)) begin
      if (w_oob) begin
        r_trap <= 1'b1;
      end else begin
        r_pc <= w_next_pc;
      end
    end
  end

  assign trap_out = r_trap;
`else
  logic w_unused_oob;
  assign w_unused_oob = w_oob;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  assign trap_out = 1'b0;
`endif

  assign pc_out        = r_pc;
  assign ins_out       = r_ir;
  assign fetch_cnt_out = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (AW=8, RESET_PC=0, PC_LIMIT=0x20).
`default_nettype none

module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [1:0]  ps_in;
  logic        il_in;
  logic [15:0] imem_data_in;
  logic [15:0] ra_in;
  logic [7:0]  pc_out;
  logic [15:0] ins_out;
  logic [15:0] fetch_cnt_out;
  logic        trap_out;

  int total = 0;
  int bad   = 0;

  fetch_unit #(
    .AW       (8),
    .RESET_PC (8'h00),
    .PC_LIMIT (8'h20)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ps_in         (ps_in),
    .il_in         (il_in),
    .imem_data_in  (imem_data_in),
    .ra_in         (ra_in),
    .pc_out        (pc_out),
    .ins_out       (ins_out),
    .fetch_cnt_out (fetch_cnt_out),
    .trap_out      (trap_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one command at a falling edge; returns at the next falling edge.
  task automatic cyc(input logic [1:0] ps, input logic il, input logic [15:0] d,
                     input logic [15:0] ra);
    ps_in        = ps;
    il_in        = il;
    imem_data_in = d;
    ra_in        = ra;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; ps_in = 2'b00; il_in = 1'b0; imem_data_in = 16'h0; ra_in = 16'h0;
    @(negedge clk);
    chk("pc_in_reset", {8'h0, pc_out}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pc",   {8'h0, pc_out}, 16'h0000);
    chk("rst_ins",  ins_out,        16'h0000);
    chk("rst_cnt",  fetch_cnt_out,  16'h0000);
    chk("rst_trap", {15'h0, trap_out}, 16'h0000);

    cyc(2'b00, 1'b1, 16'hA5C3, 16'h0);
    chk("fetch_ins", ins_out,        16'hA5C3);
    chk("fetch_cnt", fetch_cnt_out,  16'h0001);
    chk("fetch_pc",  {8'h0, pc_out}, 16'h0000);
    cyc(2'b01, 1'b0, 16'h0, 16'h0);
    chk("inc_pc",    {8'h0, pc_out}, 16'h0001);
    chk("inc_ins",   ins_out,        16'hA5C3);

    cyc(2'b11, 1'b0, 16'h0, 16'h00FF);
    chk("jmp_ff",    {8'h0, pc_out}, 16'h00FF);
    cyc(2'b01, 1'b0, 16'h0, 16'h0);
    chk("inc_wrap",  {8'h0, pc_out}, 16'h0000);

    // Branch -1 from 0x10
    cyc(2'b11, 1'b1, 16'h01C7, 16'h0010);
    chk("jmp_10",    {8'h0, pc_out}, 16'h0010);
    chk("ld_01c7",   ins_out,        16'h01C7);
    cyc(2'b10, 1'b0, 16'h0, 16'h0);
    chk("bra_m1",    {8'h0, pc_out}, 16'h000F);
    // Offset must come from old IR (-1), not the word being loaded
    cyc(2'b10, 1'b1, 16'h00C7, 16'h0);
    chk("bra_oldir", {8'h0, pc_out}, 16'h000E);
    chk("ld_00c7",   ins_out,        16'h00C7);
    cyc(2'b11, 1'b0, 16'h0, 16'h00F0);
    cyc(2'b10, 1'b0, 16'h0, 16'h0);
    chk("bra_p31",   {8'h0, pc_out}, 16'h000F);

    cyc(2'b11, 1'b1, 16'hBEEF, 16'h1234);
    chk("jmp_34",    {8'h0, pc_out}, 16'h0034);
    chk("jmp_ld",    ins_out,        16'hBEEF);
    chk("cnt_4",     fetch_cnt_out,  16'h0004);
    cyc(2'b00, 1'b0, 16'h1111, 16'h0);
    chk("hold_pc",   {8'h0, pc_out}, 16'h0034);
    chk("hold_ins",  ins_out,        16'hBEEF);

    // Asynchronous reset mid-run
    cyc(2'b11, 1'b0, 16'h0, 16'h0037);
    chk("jmp_37",    {8'h0, pc_out}, 16'h0037);
    ps_in = 2'b01; il_in = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("async_pc",  {8'h0, pc_out}, 16'h0000);
    chk("async_ins", ins_out,        16'h0000);
    chk("async_cnt", fetch_cnt_out,  16'h0000);
    @(negedge clk);
    chk("held_pc",   {8'h0, pc_out}, 16'h0000);
    rst = 1'b0; ps_in = 2'b00; il_in = 1'b0;

    // PC bounds
    cyc(2'b11, 1'b0, 16'h0, 16'h0020);
    chk("jmp_20",    {8'h0, pc_out}, 16'h0020);
    cyc(2'b01, 1'b0, 16'h0, 16'h0);
`ifdef MYCPU_PC_BOUNDS_EN
    chk("bnd_pc",    {8'h0, pc_out}, 16'h0020);
    chk("bnd_trap",  {15'h0, trap_out}, 16'h0001);
`else
    chk("bnd_pc",    {8'h0, pc_out}, 16'h0021);
    chk("bnd_trap",  {15'h0, trap_out}, 16'h0000);
`endif
    cyc(2'b11, 1'b1, 16'h2222, 16'h0005);
`ifdef MYCPU_PC_BOUNDS_EN
    chk("trap_hold", {8'h0, pc_out}, 16'h0020);
    chk("trap_stky", {15'h0, trap_out}, 16'h0001);
`else
    chk("trap_hold", {8'h0, pc_out}, 16'h0005);
    chk("trap_stky", {15'h0, trap_out}, 16'h0000);
`endif
    chk("trap_ld",   ins_out,        16'h2222);
    chk("trap_cnt",  fetch_cnt_out,  16'h0001);

    // Counter saturation: 65540 loads total after a fresh reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("sat_clr", fetch_cnt_out, 16'h0000);
    ps_in = 2'b00; il_in = 1'b1; imem_data_in = 16'h5A5A;
    repeat (65534) @(negedge clk);
    chk("sat_fffe", fetch_cnt_out, 16'hFFFE);
    repeat (6) @(negedge clk);
    chk("sat_ffff", fetch_cnt_out, 16'hFFFF);
    il_in = 1'b0;
    @(negedge clk);
    chk("sat_hold", fetch_cnt_out, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program counter and instruction register stage of mycpu; sits directly upstream of the control unit.
- Holds PC, drives the instruction-memory address, and latches the fetched word into IR when the CU asserts instruction-load.
- Applies the CU's 2-bit PC-select command (hold / increment / relative branch / register jump) each clock.
- Keeps a saturating count of fetched instructions for debug.

Parameters:
- AW, 8, PC / instruction-memory address width (bits).
- RESET_PC, 0, PC value loaded on reset.
- PC_LIMIT, 2**AW-1, highest legal PC; used only when MYCPU_PC_BOUNDS_EN is defined.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ps_in  in  2  PC select from CU: 00 hold, 01 increment, 10 branch relative, 11 jump to register.
- il_in  in  1  instruction load: IR <= imem_data_in at the next edge.
- imem_data_in  in  16  instruction word at address pc_out (combinational memory read).
- ra_in  in  16  register-file A bus; jump target.
- pc_out  out  AW  current PC; also the instruction-memory address.
- ins_out  out  16  IR contents; feeds the CU ins_in.
- fetch_cnt_out  out  16  number of IR loads since reset, saturating.
- trap_out  out  1  sticky PC-bounds violation flag.

Behaviour:
- Reset (async, rst=1):
  - pc_out=RESET_PC, ins_out=16'h0000, fetch_cnt_out=0, trap_out=0.
  - All outputs take these values immediately and hold them while rst=1.
  - Reset asserted mid-operation discards any pending update.
- PC update each rising edge (rst=0):
  - 00: pc unchanged.
  - 01: pc <= pc+1, modulo 2^AW (pc=2^AW-1 wraps to 0).
  - 10: pc <= pc + sext(off), where off = {ins_out[8:6], ins_out[2:0]}, a 6-bit two's-complement value (range -32..+31). It is sign-extended to AW bits and added modulo 2^AW. The offset always comes from the current IR, never the word being loaded.
  - 11: pc <= ra_in[AW-1:0]; upper bits of ra_in are ignored.
- IR update: il_in=1 -> ins_out <= imem_data_in; il_in=0 -> ins_out holds.
- Simultaneous il_in=1 and ps_in!=00: both updates happen in the same edge, independently. IR captures the word at the old PC; the offset uses the old IR.
- Latency:
  - pc_out changes one clock after the ps_in command.
  - ins_out changes one clock after il_in.
  - Normal sequence: CU fetch cycle (il=1, ps=00), then execute cycle (ps=01/10/11). Each instruction takes two clocks; the next fetch reads the updated PC.
- fetch_cnt_out: increments by 1 on each edge with il_in=1; saturates at 16'hFFFF with no wrap.
- No handshake: the memory read is assumed single-cycle combinational. The block never stalls.
- All outputs come directly from registers; there are no combinational input-to-output paths.

Optional Feature:
- Macro: MYCPU_PC_BOUNDS_EN.
- Defined:
  - The computed next PC is compared with PC_LIMIT after wrap.
  - If next PC > PC_LIMIT and ps_in!=00: pc holds its old value and trap_out sets to 1.
  - trap_out stays 1 until reset. While set, all further ps_in commands are treated as hold.
  - IR loads and fetch counting continue unaffected.
- Not defined: no comparison; trap_out is tied to 0 and the port still exists.

Decomposition:
- mycpu_pkg additions:
  - pc_sel_t enum {PS_HOLD=2'b00, PS_INC=2'b01, PS_BRA=2'b10, PS_JMP=2'b11}; ps_in is cast to it.
  - localparam BR_OFF_W=6.
  - Function sext_off(ins) returning the sign-extended offset.
- One combinational sub-module, pc_next_calc, takes pc, ps, IR and ra and produces next_pc plus an out-of-bounds flag.
- PC, IR, counter and trap registers live in fetch_unit.

Test Plan:
- Reset release with RESET_PC=0: fetch_cnt_out=0, pc_out=0, ins_out=0, trap_out=0; asserting rst mid-run at pc=0x37 -> pc_out=0 immediately, without waiting for a clock.
- il=1 with imem_data_in=16'hA5C3, then ps=01 -> ins_out=A5C3 and fetch_cnt=1 after the first edge; pc 0x00 -> 0x01 after the second edge; pc=0xFF with ps=01 -> 0x00.
- Branch offsets:
  - IR=16'h01C7 (off=6'b111111=-1), pc=0x10, ps=10 -> pc=0x0F.
  - IR=16'h00C7 (off=+31), pc=0xF0, ps=10 -> pc=0x0F (wraps).
- Jump: ra_in=16'h1234, ps=11 -> pc=0x34; same edge with il=1 and imem_data_in=16'hBEEF -> ins_out=BEEF.
- Counter saturation: force 65540 il pulses -> fetch_cnt_out stops at 16'hFFFF.
- With MYCPU_PC_BOUNDS_EN and PC_LIMIT=0x20: pc=0x20 with ps=01 -> pc stays 0x20 and trap_out=1; then ps=11 with ra=0x05 -> pc stays 0x20. Without the macro the same stimulus gives pc=0x21, trap_out=0.
